// File: rtl/aclock_multi.sv
// 24 h BCD time-of-day clock with NUM_ALARMS enable-gated alarm slots and a merged ring output.
// Optional snooze support is compiled in with `define ACLOCK_MULTI_SNOOZE_EN.

module aclock_slot (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr,
  input  logic [13:0] din,
  input  logic        trig,
  input  logic [13:0] now,
  input  logic        on,
  input  logic        stop,
  input  logic        park,
  input  logic        wake,
  output logic        ring
);
  logic [13:0] alarm;

  // stop and a cleared enable dominate every set source, including same-edge triggers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm <= '0;
      ring  <= 1'b0;
    end else begin
      if (wr) alarm <= din;
      ring <= on & ~stop & ((ring & ~park) | (trig & (alarm == now)) | wake);
    end
  end
endmodule

module aclock_multi #(
  parameter int CLK_DIV    = 10,
  parameter int NUM_ALARMS = 4,
  parameter int SNOOZE_MIN = 5,
  localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            H_in1,
  input  logic [3:0]            H_in0,
  input  logic [2:0]            M_in1,
  input  logic [3:0]            M_in0,
  input  logic                  LD_time,
  input  logic                  LD_alarm,
  input  logic [AW-1:0]         AL_SEL,
  input  logic [NUM_ALARMS-1:0] AL_ON,
  input  logic                  STOP_al,
`ifdef ACLOCK_MULTI_SNOOZE_EN
  input  logic                  SNOOZE,
`endif
  output logic                  Alarm,
  output logic [AW-1:0]         Alarm_id,
  output logic                  LD_err,
  output logic [1:0]            H_out1,
  output logic [3:0]            H_out0,
  output logic [2:0]            M_out1,
  output logic [3:0]            M_out0,
  output logic [2:0]            S_out1,
  output logic [3:0]            S_out0
);
  logic [PW-1:0] pre;
  logic [1:0] h1, nh1;
  logic [3:0] h0, nh0, m0, nm0, s0, ns0;
  logic [2:0] m1, nm1, s1, ns1;
  logic valid, ld_ok, tick, trig, sel_bad, lt_q, la_q;
  logic [NUM_ALARMS-1:0] ring, wr, park, wake;

  assign valid = (H_in0 <= 4'd9) && (M_in0 <= 4'd9) && (M_in1 <= 3'd5) &&
                 ((H_in1 < 2'd2) || ((H_in1 == 2'd2) && (H_in0 <= 4'd3)));
  assign sel_bad = int'(AL_SEL) >= NUM_ALARMS;
  assign ld_ok   = LD_time & valid;
  // a held valid time load freezes the clock, so ticks are suppressed while it is high
  assign tick    = ~ld_ok & (pre == PW'(CLK_DIV - 1));
  assign trig    = tick & (s1 == 3'd5) & (s0 == 4'd9);

  always_comb begin
    {nh1, nh0, nm1, nm0, ns1, ns0} = {h1, h0, m1, m0, s1, s0};
    if (s0 != 4'd9) ns0 = s0 + 4'd1;
    else begin
      ns0 = 4'd0;
      if (s1 != 3'd5) ns1 = s1 + 3'd1;
      else begin
        ns1 = 3'd0;
        if (m0 != 4'd9) nm0 = m0 + 4'd1;
        else begin
          nm0 = 4'd0;
          if (m1 != 3'd5) nm1 = m1 + 3'd1;
          else begin
            nm1 = 3'd0;
            if ((h1 == 2'd2) && (h0 == 4'd3)) begin
              nh1 = 2'd0;
              nh0 = 4'd0;
            end else if (h0 == 4'd9) begin
              nh0 = 4'd0;
              nh1 = h1 + 2'd1;
            end else nh0 = h0 + 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre <= '0;
      {h1, h0, m1, m0, s1, s0} <= '0;
    end else if (ld_ok) begin
      pre <= '0;
      {h1, h0, m1, m0, s1, s0} <= {H_in1, H_in0, M_in1, M_in0, 3'd0, 4'd0};
    end else if (tick) begin
      pre <= '0;
      {h1, h0, m1, m0, s1, s0} <= {nh1, nh0, nm1, nm0, ns1, ns0};
    end else begin
      pre <= pre + PW'(1);
    end
  end

  // error reported only on the first cycle of a load so a held bad load pulses once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lt_q   <= 1'b0;
      la_q   <= 1'b0;
      LD_err <= 1'b0;
    end else begin
      lt_q   <= LD_time;
      la_q   <= LD_alarm;
      LD_err <= (LD_time & ~lt_q & ~valid) |
                (LD_alarm & ~LD_time & ~la_q & (~valid | sel_bad));
    end
  end

`ifdef ACLOCK_MULTI_SNOOZE_EN
  localparam int SNZ = SNOOZE_MIN * 60;
  localparam int CW  = $clog2(SNZ + 1);
  logic [NUM_ALARMS-1:0] snoozed;
  logic [CW-1:0]         snz_cnt;
  logic                  take, expire;

  assign take   = SNOOZE & Alarm & ~STOP_al;
  assign expire = tick & (|snoozed) & (snz_cnt == CW'(1));
  assign park   = {NUM_ALARMS{take}};
  assign wake   = expire ? snoozed : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snoozed <= '0;
      snz_cnt <= '0;
    end else if (STOP_al || ld_ok) begin
      snoozed <= '0;
      snz_cnt <= '0;
    end else if (take) begin
      snoozed <= snoozed | ring;
      snz_cnt <= CW'(SNZ);
    end else if (tick && (|snoozed)) begin
      if (expire) snoozed <= '0;
      snz_cnt <= snz_cnt - CW'(1);
    end
  end
`else
  assign park = '0;
  assign wake = '0;
`endif

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_slot
    assign wr[i] = LD_alarm & ~LD_time & valid & (int'(AL_SEL) == i);
    aclock_slot u_slot (
      .clk  (clk),
      .rst_n(reset),
      .wr   (wr[i]),
      .din  ({H_in1, H_in0, M_in1, M_in0}),
      .trig (trig),
      .now  ({nh1, nh0, nm1, nm0}),
      .on   (AL_ON[i]),
      .stop (STOP_al),
      .park (park[i]),
      .wake (wake[i]),
      .ring (ring[i])
    );
  end

  assign Alarm = |ring;

  always_comb begin
    Alarm_id = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--)
      if (ring[i]) Alarm_id = AW'(i);
  end

  assign {H_out1, H_out0, M_out1, M_out0, S_out1, S_out0} = {h1, h0, m1, m0, s1, s0};
endmodule

// File: tb/tb_aclock_multi.sv
// Self-checking bench for aclock_multi: directed scenarios plus random traffic against a
// seconds-of-day / minutes-of-day reference model.

module tb_aclock_multi;
  localparam int CD = 2;
  localparam int NA = 4;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] H_in1;
  logic [3:0] H_in0;
  logic [2:0] M_in1;
  logic [3:0] M_in0;
  logic LD_time, LD_alarm, STOP_al, SNOOZE;
  logic [1:0] AL_SEL;
  logic [NA-1:0] AL_ON;
  logic Alarm, LD_err;
  logic [1:0] Alarm_id, H_out1;
  logic [3:0] H_out0, M_out0, S_out0;
  logic [2:0] M_out1, S_out1;

  aclock_multi #(.CLK_DIV(CD), .NUM_ALARMS(NA), .SNOOZE_MIN(1)) dut (
    .clk(clk), .reset(reset),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .AL_SEL(AL_SEL), .AL_ON(AL_ON),
    .STOP_al(STOP_al),
`ifdef ACLOCK_MULTI_SNOOZE_EN
    .SNOOZE(SNOOZE),
`endif
    .Alarm(Alarm), .Alarm_id(Alarm_id), .LD_err(LD_err),
    .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
    .S_out1(S_out1), .S_out0(S_out0)
  );

  always #5 clk = ~clk;

  // reference model: time as seconds of day, alarms as minutes of day
  int m_pre, m_t;
  int m_alm[NA];
  logic [NA-1:0] m_ring;
  logic m_err, m_plt, m_pla;
  int total = 0, bad = 0;

  function automatic logic [23:0] dut_vec();
    return {Alarm, Alarm_id, LD_err, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0};
  endfunction

  function automatic logic [23:0] exp_vec();
    int h, m, s, id;
    h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
    id = 0;
    for (int i = NA - 1; i >= 0; i--) if (m_ring[i]) id = i;
    return {|m_ring, 2'(id), m_err, 2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10),
            3'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_reset();
    m_pre = 0; m_t = 0; m_ring = '0; m_err = 0; m_plt = 0; m_pla = 0;
    for (int i = 0; i < NA; i++) m_alm[i] = 0;
  endtask

  task automatic model_edge();
    int hv, mv;
    bit ok, tick, nerr;
    hv = int'(H_in1) * 10 + int'(H_in0);
    mv = int'(M_in1) * 10 + int'(M_in0);
    ok = (H_in0 <= 9) && (M_in0 <= 9) && (M_in1 <= 5) && (hv <= 23);
    tick = 0; nerr = 0;
    if (LD_time && ok) begin
      m_t = hv * 3600 + mv * 60; m_pre = 0;
    end else if (m_pre == CD - 1) begin
      m_pre = 0; m_t = (m_t + 1) % 86400; tick = 1;
    end else m_pre++;
    for (int i = 0; i < NA; i++) begin
      if (tick && (m_t % 60 == 0) && (m_alm[i] == m_t / 60) && AL_ON[i]) m_ring[i] = 1'b1;
      if (STOP_al || !AL_ON[i]) m_ring[i] = 1'b0;
    end
    if (LD_time && !m_plt && !ok) nerr = 1;
    if (!LD_time && LD_alarm) begin
      if (ok && int'(AL_SEL) < NA) m_alm[AL_SEL] = hv * 60 + mv;
      else if (!m_pla) nerr = 1;
    end
    m_err = nerr; m_plt = LD_time; m_pla = LD_alarm;
  endtask

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check(tag, dut_vec(), exp_vec());
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  task automatic digits(input int h1, input int h0, input int m1, input int m0);
    H_in1 = 2'(h1); H_in0 = 4'(h0); M_in1 = 3'(m1); M_in0 = 4'(m0);
  endtask

  task automatic load_time(input int h, input int m);
    digits(h / 10, h % 10, m / 10, m % 10);
    LD_time = 1; cyc("ld_time"); LD_time = 0;
  endtask

  task automatic load_alarm(input int sel, input int h, input int m);
    digits(h / 10, h % 10, m / 10, m % 10);
    AL_SEL = 2'(sel); LD_alarm = 1; cyc("ld_alarm"); LD_alarm = 0;
  endtask

  initial begin
    reset = 0; SNOOZE = 0; LD_time = 0; LD_alarm = 0; STOP_al = 0; AL_ON = '0; AL_SEL = '0;
    digits(0, 0, 0, 0);
    model_reset();
    #12;
    check("reset_state", dut_vec(), 24'h0);
    reset = 1;

    // full-day wrap with second, minute and hour carries
    load_time(23, 59);
    run(119, "carry");
    cyc("carry_end");
    check("midnight", dut_vec(), 24'h0);

    // single slot trigger on the :00 display, then stop
    load_alarm(2, 7, 0);
    AL_ON = 4'b0100;
    load_time(6, 59);
    run(116, "pre_alarm");
    run(3, "approach");
    cyc("ring_edge");
    check("ring_slot2", dut_vec(), {1'b1, 2'd2, 1'b0, 2'd0, 4'd7, 3'd0, 4'd0, 3'd0, 4'd0});
    STOP_al = 1; cyc("stop"); STOP_al = 0;
    check("stopped", {23'h0, Alarm}, 24'h0);

    // two matching slots, lowest index wins, then drop its enable
    load_alarm(1, 8, 15);
    load_alarm(3, 8, 15);
    AL_ON = 4'b1010;
    load_time(8, 14);
    run(120, "dual");
    check("dual_id1", {21'h0, Alarm, Alarm_id}, 24'h5);
    AL_ON = 4'b1000; cyc("drop1");
    check("dual_id3", {21'h0, Alarm, Alarm_id}, 24'h7);
    AL_ON = 4'b0001; STOP_al = 1; cyc("clr"); STOP_al = 0;

    // rejected loads pulse once, held or not
    digits(2, 4, 0, 0); LD_time = 1; cyc("bad_time");
    check("err_time", {23'h0, LD_err}, 24'h1);
    cyc("bad_time_hold");
    check("err_time_once", {23'h0, LD_err}, 24'h0);
    LD_time = 0;
    digits(1, 0, 6, 0); AL_SEL = 2'd0; LD_alarm = 1; cyc("bad_alarm");
    check("err_alarm", {23'h0, LD_err}, 24'h1);
    cyc("bad_alarm_hold");
    LD_alarm = 0;
    // both loads together: time wins, slot 0 keeps 00:00
    digits(1, 1, 3, 0); AL_SEL = 2'd0; LD_time = 1; LD_alarm = 1; cyc("both");
    LD_time = 0; LD_alarm = 0;
    check("both_time", dut_vec(), {1'b0, 2'd0, 1'b0, 2'd1, 4'd1, 3'd3, 4'd0, 3'd0, 4'd0});
    load_time(11, 29);
    run(120, "no_slot_write");
    check("slot0_kept", {23'h0, Alarm}, 24'h0);

    // random traffic; alarm loads often target the upcoming minute
    AL_ON = 4'b1111;
    for (int n = 0; n < 600; n++) begin
      LD_time  = ($urandom_range(0, 59) == 0);
      LD_alarm = ($urandom_range(0, 11) == 0);
      STOP_al  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 29) == 0) AL_ON = 4'($urandom_range(0, 15));
      AL_SEL = 2'($urandom_range(0, 3));
      if (LD_alarm && $urandom_range(0, 1) == 1) begin
        int mm;
        mm = (m_t / 60 + 1) % 1440;
        digits(mm / 600, (mm / 60) % 10, (mm % 60) / 10, mm % 10);
      end else
        digits($urandom_range(0, 3), $urandom_range(0, 11), $urandom_range(0, 6),
               $urandom_range(0, 10));
      cyc("random");
    end
    LD_time = 0; LD_alarm = 0; STOP_al = 0;

    // asynchronous reset mid-count at 12:34:56
    AL_ON = '0;
    load_time(12, 34);
    run(112, "to_1234");
    check("at_123456", dut_vec(), {4'h0, 2'd1, 4'd2, 3'd3, 4'd4, 3'd5, 4'd6});
    #2 reset = 0;
    #1 check("async_reset", dut_vec(), 24'h0);
    #2 reset = 1;
    model_reset();
    run(6, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
